// File: rtl/sdp_ram_ctrl_pkg.sv
// sdp_ram_ctrl_pkg: shared helpers for the SDP RAM front end.
//   addr_width(depth) : address bits needed for a RAM of 'depth' words (min 1)
//   id_width(num_req) : requester index bits for 'num_req' requesters (min 1)
//   rsp_flags_t       : flag part of the read response (valid); the sized id and
//                       data fields are added by sdp_ram_ctrl, which knows the widths.
package sdp_ram_ctrl_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return clog2_min1(depth);
  endfunction

  function automatic int unsigned id_width(input int unsigned num_req);
    return clog2_min1(num_req);
  endfunction

  typedef struct packed {
    logic valid;
  } rsp_flags_t;

endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter with a registered priority pointer.
//   clk       in  clock
//   rst       in  synchronous active-high reset; pointer -> 0, grants forced off
//   req       in  N request lines
//   grant     out N one-hot grant (all zero when nothing requests)
//   grant_idx out index of the granted line (0 when no grant)
// Search starts at the pointer and wraps N-1 -> 0; after a grant to g the
// pointer moves to (g+1) mod N, otherwise it holds.
module rr_arb
  import sdp_ram_ctrl_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = id_width(N),
  localparam int unsigned SumW = IdxW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx
);

  logic [IdxW-1:0] ptr_q;
  logic            found;
  logic [SumW-1:0] sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    if (!rst) begin
      for (int unsigned off = 0; off < N; off++) begin
        // One extra bit so ptr+off cannot overflow before the modulo wrap.
        sum = {1'b0, ptr_q} + SumW'(off);
        if (sum >= SumW'(N)) sum = sum - SumW'(N);
        cand = sum[IdxW-1:0];
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sdp_ram_ctrl.sv
// sdp_ram_ctrl: NUM_REQ-requester front end for one simple-dual-port RAM.
// Writes and reads are arbitrated by independent round-robin arbiters, so one
// write and one read may issue per cycle. Read data returns one cycle after the
// grant, tagged with the requester index.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/req_wr       per-requester handshake and direction
//   req_addr/req_wdata               flattened per-requester address/data
//   rsp_valid/rsp_id/rsp_data        read response (no backpressure)
//   ram_wr_en/ram_wr_addr/ram_wr_data  RAM write port
//   ram_rd_en/ram_rd_addr/ram_rd_data  RAM read port (1-cycle latency)
// Build option: define SDP_RAM_CTRL_FWD_EN to return the new write data on a
// same-cycle read/write collision instead of the old RAM contents.
module sdp_ram_ctrl
  import sdp_ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned NUM_REQ    = 4,
  localparam int unsigned AW = addr_width(DATA_DEPTH),
  localparam int unsigned IW = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*AW-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                          rsp_valid,
  output logic [IW-1:0]                 rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_wr_en,
  output logic [AW-1:0]                 ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic                          ram_rd_en,
  output logic [AW-1:0]                 ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

  typedef struct packed {
    rsp_flags_t            flags;
    logic [IW-1:0]         id;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  logic [AW-1:0]         addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AW +: AW];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [NUM_REQ-1:0] wr_cand, rd_cand, wr_grant, rd_grant;
  logic [IW-1:0]      wr_idx, rd_idx;

  assign wr_cand = req_valid & req_wr;
  assign rd_cand = req_valid & ~req_wr;

  rr_arb #(
    .N(NUM_REQ)
  ) u_wr_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (wr_cand),
    .grant    (wr_grant),
    .grant_idx(wr_idx)
  );

  rr_arb #(
    .N(NUM_REQ)
  ) u_rd_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (rd_cand),
    .grant    (rd_grant),
    .grant_idx(rd_idx)
  );

  // Arbiters already suppress grants during reset.
  assign req_ready   = wr_grant | rd_grant;
  assign ram_wr_en   = |wr_grant;
  assign ram_wr_addr = addr_arr[wr_idx];
  assign ram_wr_data = wdata_arr[wr_idx];
  assign ram_rd_en   = |rd_grant;
  assign ram_rd_addr = addr_arr[rd_idx];

  logic          rsp_valid_q;
  logic [IW-1:0] rsp_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= ram_rd_en;
      if (ram_rd_en) rsp_id_q <= rd_idx;
    end
  end

  rsp_t rsp;

  // Masked by rst so a read granted just before reset never surfaces.
  assign rsp.flags.valid = rsp_valid_q & ~rst;
  assign rsp.id          = rsp_id_q;

`ifdef SDP_RAM_CTRL_FWD_EN
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= ram_wr_en & ram_rd_en & (ram_wr_addr == ram_rd_addr);
      fwd_data_q <= ram_wr_data;
    end
  end

  assign rsp.data = fwd_q ? fwd_data_q : ram_rd_data;
`else
  assign rsp.data = ram_rd_data;
`endif

  assign rsp_valid = rsp.flags.valid;
  assign rsp_id    = rsp.id;
  assign rsp_data  = rsp.data;

endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// Randomised scoreboard bench for sdp_ram_ctrl. A behavioural RAM sits on the
// RAM ports; a reference model (round-robin search, word array) predicts
// grants and read responses, which a separate monitor compares.
module tb_sdp_ram_ctrl;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid, req_ready, req_wr;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              ram_wr_en, ram_rd_en;
  logic [AW-1:0]     ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]     ram_wr_data;
  logic [DW-1:0]     ram_rd_data = '0;

  sdp_ram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Environment RAM: registered read, read-before-write on collision.
  logic [DW-1:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
  end

  // Requester-side stimulus state.
  logic [N-1:0]  v_valid, v_wr;
  logic [AW-1:0] v_addr  [N];
  logic [DW-1:0] v_wdata [N];

  // Reference model state.
  logic [DW-1:0] ref_mem [1024];
  int            wptr, rptr;
  bit            exp_rsp_now;
  logic [N-1:0]  last_exp_rdy, last_ready_act;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] c);
    for (int k = 0; k < N; k++) if (c[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic drive();
    req_valid = v_valid;
    req_wr    = v_wr;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = v_addr[i];
      req_wdata[i*DW +: DW] = v_wdata[i];
    end
  endtask

  task automatic model_and_check();
    logic [N-1:0]  wc, rc, exp_rdy;
    int            gw, gr;
    exp_t          e;
    wc = v_valid & v_wr;
    rc = v_valid & ~v_wr;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_now && !rst));
    gw = rst ? -1 : pick(wptr, wc);
    gr = rst ? -1 : pick(rptr, rc);
    exp_rdy = '0;
    if (gw >= 0) exp_rdy[gw] = 1'b1;
    if (gr >= 0) exp_rdy[gr] = 1'b1;
    last_ready_act = req_ready;
    last_exp_rdy   = exp_rdy;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("ram_wr_en", 32'(ram_wr_en), 32'(gw >= 0));
    check("ram_rd_en", 32'(ram_rd_en), 32'(gr >= 0));
    if (gw >= 0) begin
      check("ram_wr_addr", 32'(ram_wr_addr), 32'(v_addr[gw]));
      check("ram_wr_data", 32'(ram_wr_data), 32'(v_wdata[gw]));
    end
    if (gr >= 0) begin
      check("ram_rd_addr", 32'(ram_rd_addr), 32'(v_addr[gr]));
      e.id   = gr;
      e.data = ref_mem[v_addr[gr]];
`ifdef SDP_RAM_CTRL_FWD_EN
      if (gw >= 0 && v_addr[gw] == v_addr[gr]) e.data = v_wdata[gw];
`endif
      exp_q.push_back(e);
    end
    if (gw >= 0) ref_mem[v_addr[gw]] = v_wdata[gw];
    if (rst) begin
      wptr = 0;
      rptr = 0;
      exp_q.delete();
    end else begin
      if (gw >= 0) wptr = (gw + 1) % N;
      if (gr >= 0) rptr = (gr + 1) % N;
    end
    exp_rsp_now = (gr >= 0);
  endtask

  // Called at posedge+1 with v_* already set; returns at the next posedge+1.
  task automatic run_cycle();
    drive();
    #1;
    model_and_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    v_valid = '0;
    v_wr    = '0;
  endtask

  task automatic put_req(input int i, input bit wr, input int addr, input logic [DW-1:0] d);
    v_valid[i] = 1'b1;
    v_wr[i]    = wr;
    v_addr[i]  = AW'(addr);
    v_wdata[i] = d;
  endtask

  // Monitor: compares every presented response against the scoreboard.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data 0x%0h, expected no response", rsp_id,
                 rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  initial begin
    for (int a = 0; a < 1024; a++) begin
      ram_mem[a] = '0;
      ref_mem[a] = '0;
    end
    for (int i = 0; i < N; i++) begin
      v_addr[i]  = '0;
      v_wdata[i] = '0;
    end
    wptr = 0;
    rptr = 0;
    exp_rsp_now = 0;
    set_idle();
    drive();
    @(posedge clk);
    #1;

    // Reset with requests pending: nothing may be granted.
    rst = 1'b1;
    v_valid = 4'hF;
    v_wr    = 4'h5;
    run_cycle();
    run_cycle();
    rst = 1'b0;
    set_idle();
    check("rsp_id_after_reset", 32'(rsp_id), 32'd0);

    // Requester 2 writes then reads address 5.
    put_req(2, 1'b1, 5, 16'h1234);
    run_cycle();
    set_idle();
    put_req(2, 1'b0, 5, 16'h0);
    run_cycle();
    set_idle();
    check("rd_after_wr_data", 32'(rsp_data), 32'h1234);
    run_cycle();

    // Four contending reads after reset: grants 0,1,2,3,0.
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) put_req(i, 1'b0, i, 16'h0);
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      check("rr_order", 32'(last_ready_act), 32'(1 << (k % N)));
    end
    set_idle();
    run_cycle();

    // Concurrent write (req 1) and read (req 3), different addresses.
    put_req(1, 1'b1, 10, 16'hBEEF);
    put_req(3, 1'b0, 20, 16'h0);
    run_cycle();
    check("wr_rd_same_cycle_ready", 32'(last_ready_act), 32'b1010);
    set_idle();
    run_cycle();

    // Same-address collision: old data unless forwarding is built in.
    put_req(0, 1'b1, 7, 16'hAAAA);
    run_cycle();
    set_idle();
    put_req(0, 1'b1, 7, 16'h5555);
    put_req(1, 1'b0, 7, 16'h0);
    run_cycle();
    set_idle();
`ifdef SDP_RAM_CTRL_FWD_EN
    check("collision_data", 32'(rsp_data), 32'h5555);
`else
    check("collision_data", 32'(rsp_data), 32'hAAAA);
`endif
    run_cycle();

    // Read granted, then reset next cycle: response suppressed, pointers cleared.
    put_req(1, 1'b0, 3, 16'h0);
    run_cycle();
    rst = 1'b1;
    v_valid = 4'hF;
    v_wr    = 4'hF;
    run_cycle();
    check("ready_in_reset", 32'(last_ready_act), 32'd0);
    rst = 1'b0;
    run_cycle();
    check("first_grant_after_reset", 32'(last_ready_act), 32'b0001);
    set_idle();
    run_cycle();

    // Randomised traffic with occasional reset; requesters hold until granted.
    for (int c = 0; c < 800; c++) begin
      v_valid &= ~last_exp_rdy;
      for (int i = 0; i < N; i++) begin
        if (!v_valid[i] && $urandom_range(0, 9) < 6) begin
          put_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), DW'($urandom));
        end
      end
      rst = ($urandom_range(0, 59) == 0);
      run_cycle();
    end
    rst = 1'b0;
    set_idle();
    repeat (3) run_cycle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_ram_ctrl.md
# sdp_ram_ctrl

Multi-requester front end for one simple-dual-port RAM (`sdp_ram`: one write port, one registered read port, 1-cycle read latency). It arbitrates NUM_REQ requesters onto the RAM ports and returns read data tagged with the requester ID. The write port and the read port are arbitrated independently, so one write and one read can issue in the same cycle. The block sits between the client blocks and the RAM and drives all RAM ports directly.

## Interface
- DATA_WIDTH, 16, RAM word width
- DATA_DEPTH, 1024, RAM words; AW = $clog2(DATA_DEPTH)
- NUM_REQ, 4, requester count, ≥2; IW = $clog2(NUM_REQ)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*AW  flattened addresses; requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- rsp_valid  out  1  read response valid
- rsp_id  out  IW  requester index of the response
- rsp_data  out  DATA_WIDTH  read response data
- ram_wr_en / ram_wr_addr / ram_wr_data  out  1 / AW / DATA_WIDTH  RAM write port
- ram_rd_en / ram_rd_addr  out  1 / AW  RAM read port
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after ram_rd_en

## Operation
- Write candidates: `req_valid[i] & req_wr[i]`. Read candidates: `req_valid[i] & ~req_wr[i]`. Each class has its own round-robin arbiter.
- Each arbiter grants at most one candidate per cycle. Priority starts at its pointer and wraps NUM_REQ-1 → 0.
- After a grant to index g, the pointer becomes (g+1) mod NUM_REQ. With no grant, the pointer holds.
- `req_ready[i]` is 1 iff requester i is granted by either arbiter. Ready is combinational from valid, so requesters must not derive valid from ready.
- A transfer occurs when valid & ready. Requesters hold valid, wr, addr and wdata stable until ready.
- Write grant g: ram_wr_en=1, ram_wr_addr/ram_wr_data = requester g's fields, same cycle.
- Read grant g: ram_rd_en=1, ram_rd_addr = requester g's address, same cycle. The ID is registered.
- Read response: next cycle, rsp_valid=1, rsp_id=g, rsp_data=ram_rd_data. There is no response backpressure; clients must sink it.
- Simultaneous read and write to the same address in one cycle: rsp_data is the old RAM contents unless forwarding is compiled in (see Configuration).
- Idle: ram_wr_en=0, ram_rd_en=0. Address and data outputs are don't-care when not enabled.

## Timing
- Grant latency: 0 cycles, combinational ready.
- Read latency: grant in cycle N → rsp_valid in cycle N+1. Back-to-back reads give one response per cycle.
- Reset values: both pointers = 0, rsp_valid=0, rsp_id=0.
- While rst=1, these are forced to 0: req_ready, ram_wr_en, ram_rd_en.
- Reset mid-operation: a read granted in the cycle before rst asserts produces no response, because rsp_valid is cleared. A write issued before reset stays in the RAM.
- After rst deasserts, requester 0 wins first in each class when contended.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of its class's contention.

## Configuration
- `SDP_RAM_CTRL_FWD_EN` defined: a same-cycle read and write to an equal address sets a registered forward flag and captures the write data. The next cycle's rsp_data is the captured write data (new value).
- Not defined: rsp_data always equals ram_rd_data (old value on collision). No forward registers are built.

## Structure
- Package `sdp_ram_ctrl_pkg`: localparam helper functions for AW and IW, and the response struct type (valid, id, data).
- One sub-module is natural: `rr_arb`. It is parameterised by N and takes req[N] to grant[N] one-hot plus grant_idx. It holds its own pointer with sync active-high reset. It is instantiated twice, once for writes and once for reads.

## Test plan
- Reset, then requester 2 writes 0x1234 to addr 5, then reads addr 5 → write issues in cycle 0; read response in the following cycle shows rsp_valid=1, rsp_id=2, rsp_data=0x1234.
- Requesters 0–3 all hold valid reads to addrs 0–3 → grants go 0,1,2,3,0 in consecutive cycles; rsp_id sequence 0,1,2,3 lags by one cycle.
- Requester 1 writes and requester 3 reads in the same cycle, different addresses → both ready=1, ram_wr_en=ram_rd_en=1, and the response goes to id 3.
- Addr 7 holds 0xAAAA; requester 0 writes 0x5555 to addr 7 while requester 1 reads addr 7 → rsp_data is 0xAAAA without `SDP_RAM_CTRL_FWD_EN` and 0x5555 with it.
- Read granted to requester 1, rst asserted the next cycle → rsp_valid=0 and all ready=0 during reset; the first contended grant after reset goes to requester 0.
